// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, rcon constants, block/word types,
// GF(2^8) doubling and the key-schedule FSM state encoding.
package aes_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } aes_state_e;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel forward AES S-box lookups on a 32-bit word; table based,
// purely combinational, shared with the SubBytes stage.
module aes_sbox_word
    import aes_pkg::*;
(
    input  aes_word_t din,
    output aes_word_t dout
);

    // Byte 0x00 sits in the most significant byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        sbox_byte = SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    assign dout = {sbox_byte(din[31:24]), sbox_byte(din[23:16]),
                   sbox_byte(din[15:8]),  sbox_byte(din[7:0])};

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: emits round keys 0..10 over valid/ready,
// computing each key on the fly from the previous one.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);

    generate
        if (NR != AES_NR) begin : g_bad_nr
            $error("aes_key_expand_seq supports only NR = 10");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    aes_state_e state_r, state_nxt_s;
    aes_block_t key_r, key_nxt_s, next_key_s;
    logic [3:0] round_r, round_nxt_s;
    logic [7:0] rcon_r, rcon_nxt_s;
    logic       valid_r, valid_nxt_s;
    logic       busy_r, busy_nxt_s;
    logic       done_r, done_nxt_s;
    aes_word_t  rot_s, sub_s, t_s;
    aes_word_t  w0_s, w1_s, w2_s, w3_s;

    assign rot_s = {key_r[23:0], key_r[31:24]};

    aes_sbox_word u_sbox (
        .din  (rot_s),
        .dout (sub_s)
    );

    assign t_s        = sub_s ^ {rcon_r, 24'h000000};
    assign w0_s       = key_r[127:96] ^ t_s;
    assign w1_s       = key_r[95:64]  ^ w0_s;
    assign w2_s       = key_r[63:32]  ^ w1_s;
    assign w3_s       = key_r[31:0]   ^ w2_s;
    assign next_key_s = {w0_s, w1_s, w2_s, w3_s};

    // Next-state and next-output decode for the load/stall/advance/finish cases.
    always_comb begin
        state_nxt_s = state_r;
        key_nxt_s   = key_r;
        round_nxt_s = round_r;
        rcon_nxt_s  = rcon_r;
        valid_nxt_s = valid_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (key_load) begin
                    state_nxt_s = RUN;
                    key_nxt_s   = key_in;
                    round_nxt_s = 4'd0;
                    rcon_nxt_s  = RCON_INIT;
                    valid_nxt_s = 1'b1;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (valid_r && rk_ready) begin
                    if (round_r == LAST_ROUND) begin
                        state_nxt_s = IDLE;
                        valid_nxt_s = 1'b0;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else begin
                        key_nxt_s   = next_key_s;
                        round_nxt_s = round_r + 4'd1;
                        rcon_nxt_s  = xtime(rcon_r);
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                valid_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            key_r   <= 128'h0;
            round_r <= 4'd0;
            rcon_r  <= RCON_INIT;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            key_r   <= key_nxt_s;
            round_r <= round_nxt_s;
            rcon_r  <= rcon_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign rk_out   = key_r;
    assign rk_round = round_r;
    assign rk_valid = valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: FIPS-197 expansion model built
// from GF(2^8) arithmetic, checked against the DUT on every negative edge.
module tb_aes_key_expand_seq;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = 128'h0;
    logic         key_load = 1'b0;
    logic         rk_ready = 1'b0;
    logic         busy, rk_valid, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [0:255];

    aes_key_expand_seq dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_load (key_load),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gf_mul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] expand_key(input logic [127:0] k, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Reference model of the handshake, checked every cycle.
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    int           m_idx  = 0;
    logic [127:0] m_key  = 128'h0;
    logic [127:0] m_hold_key = 128'h0;
    logic [3:0]   m_hold_round = 4'd0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_idx = 0;
            m_hold_key = 128'h0; m_hold_round = 4'd0;
        end else begin
            check("busy", 128'(busy), 128'(m_busy));
            check("rk_valid", 128'(rk_valid), 128'(m_busy));
            check("done", 128'(done), 128'(m_done));
            if (m_busy) begin
                m_hold_key   = expand_key(m_key, m_idx);
                m_hold_round = 4'(m_idx);
            end
            check("rk_out", rk_out, m_hold_key);
            check("rk_round", 128'(rk_round), 128'(m_hold_round));
            m_done = 1'b0;
            if (!m_busy) begin
                if (key_load) begin
                    m_key = key_in; m_idx = 0; m_busy = 1'b1;
                end
            end else if (rk_ready) begin
                if (m_idx == 10) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_round(input logic [3:0] r, input string name);
        bit hit = 1'b0;
        for (int c = 0; c < 64 && !hit; c++) begin
            if (rk_valid && rk_round == r) hit = 1'b1;
            else step();
        end
        check(name, 128'(hit), 128'(1'b1));
    endtask

    // Load k (in the current cycle), drain all 11 keys, return on the done cycle.
    task automatic run_key(input logic [127:0] k, input bit throttle,
                           input logic [127:0] lit1, input logic [127:0] lit10);
        int vcycles = 0;
        int hs = 0;
        bit seen_done = 1'b0;
        key_in = k; key_load = 1'b1;
        step();
        key_load = 1'b0;
        check("load_valid", 128'(rk_valid), 128'(1'b1));
        check("load_round0", 128'(rk_round), 128'(4'd0));
        check("load_key", rk_out, k);
        for (int c = 0; c < 400 && !seen_done; c++) begin
            if (done) seen_done = 1'b1;
            else begin
                rk_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rk_valid) begin
                    vcycles++;
                    if (rk_ready) hs++;
                    if (rk_round == 4'd1) check("lit_round1", rk_out, lit1);
                    if (rk_round == 4'd10) begin
                        check("lit_round10", rk_out, lit10);
                        check("busy_round10", 128'(busy), 128'(1'b1));
                    end
                end
                step();
            end
        end
        check("done_reached", 128'(seen_done), 128'(1'b1));
        check("busy_on_done", 128'(busy), 128'(1'b0));
        check("handshakes", 128'(hs), 128'(11));
        if (!throttle) check("valid_cycles", 128'(vcycles), 128'(11));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_sbox();
        check("model_fips_r1", expand_key(FIPS_KEY, 1), FIPS_R1);
        check("model_fips_r2", expand_key(FIPS_KEY, 2), FIPS_R2);
        check("model_fips_r10", expand_key(FIPS_KEY, 10), FIPS_R10);
        check("model_zero_r1", expand_key(ZERO_KEY, 1), ZERO_R1);
        check("model_zero_r10", expand_key(ZERO_KEY, 10), ZERO_R10);

        repeat (2) step();
        check("rst_rk_out", rk_out, 128'h0);
        check("rst_rk_round", 128'(rk_round), 128'h0);
        check("rst_valid_busy_done", 128'({rk_valid, busy, done}), 128'h0);
        rst = 1'b0;
        step();

        run_key(FIPS_KEY, 1'b0, FIPS_R1, FIPS_R10);
        step();
        check("done_one_cycle", 128'(done), 128'(1'b0));
        run_key(ZERO_KEY, 1'b0, ZERO_R1, ZERO_R10);
        run_key(FIPS_KEY, 1'b1, FIPS_R1, FIPS_R10);

        // Loads during busy and on the final handshake are ignored.
        rk_ready = 1'b1;
        key_in = FIPS_KEY; key_load = 1'b1;
        step();
        key_load = 1'b0;
        wait_round(4'd4, "reach_round4");
        key_in = ZERO_KEY; key_load = 1'b1;
        step();
        key_load = 1'b0; key_in = FIPS_KEY;
        wait_round(4'd10, "reach_round10");
        check("ign_round10_key", rk_out, FIPS_R10);
        key_in = ZERO_KEY; key_load = 1'b1;
        step();
        check("ign_done_pulse", 128'(done), 128'(1'b1));
        step();
        key_load = 1'b0;
        check("done_load_valid", 128'(rk_valid), 128'(1'b1));
        check("done_load_round", 128'(rk_round), 128'(4'd0));
        check("done_load_key", rk_out, ZERO_KEY);
        wait_round(4'd10, "drain_round10");
        step();

        // Asynchronous reset mid-sequence.
        key_in = FIPS_KEY; key_load = 1'b1;
        step();
        key_load = 1'b0;
        wait_round(4'd6, "reach_round6");
        #2 rst = 1'b1;
        #1;
        check("arst_rk_out", rk_out, 128'h0);
        check("arst_rk_round", 128'(rk_round), 128'h0);
        check("arst_valid_busy_done", 128'({rk_valid, busy, done}), 128'h0);
        step();
        rst = 1'b0;
        run_key(FIPS_KEY, 1'b0, FIPS_R1, FIPS_R10);

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) run_key(ZERO_KEY, 1'b0, ZERO_R1, ZERO_R10);
            else            run_key(FIPS_KEY, 1'b0, FIPS_R1, FIPS_R10);
        end
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
